pcf8563_ctrl: RTL

Transaction sequencer that sits directly upstream of the byte-level I2C master. It drives the master's call/done interface to run the following operations:
- Initialise the PCF8563 RTC after reset.
- Poll the seconds, minutes and hours registers periodically.
- Service user set-time requests.
It publishes a coherent BCD time snapshot to the display/timepiece logic.

---
 rtl/pcf8563_ctrl.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pcf8563_ctrl.sv
// PCF8563 RTC transaction sequencer driving a byte-level I2C master over call/done.
// Runs the init writes, periodic sec/min/hour polls and user set-time writes.
module pcf8563_ctrl #(
    parameter int unsigned POLL_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT     = 1_000_000,
    parameter bit          INIT_EN     = 1'b1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    output logic [1:0] oCall,
    output logic [7:0] oAddr,
    output logic [7:0] oWrData,
    input  logic [7:0] iRdData,
    input  logic       iDone,
    input  logic       iSetReq,
    input  logic [7:0] iSetSec,
    input  logic [7:0] iSetMin,
    input  logic [7:0] iSetHour,
    output logic       oSetAck,
    output logic [7:0] oSec,
    output logic [7:0] oMin,
    output logic [7:0] oHour,
    output logic       oVL,
    output logic       oValid,
    output logic       oBusy,
    output logic       oErr
);
    localparam int PC_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [1:0] CALL_WR = 2'b10;
    localparam logic [1:0] CALL_RD = 2'b01;

    typedef enum logic [2:0] {
        S_INIT,
        S_WAIT,
        S_POLL,
        S_PUBLISH,
        S_SET
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic            issue_q, issue_d;
    logic [1:0]      call_q, call_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic [PC_W-1:0] poll_q, poll_d;
    logic            pend_q, pend_d;
    logic            first_q, first_d;
    logic            err_q, err_d;
    logic [7:0]      sh02_q, sh02_d;
    logic [7:0]      sh03_q, sh03_d;
    logic [7:0]      smin_q, smin_d;
    logic [7:0]      shour_q, shour_d;
    logic [7:0]      sec_q, sec_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      hour_q, hour_d;
    logic            vl_q, vl_d;
    logic            valid_q, valid_d;
    logic            ack_q, ack_d;
    logic            go_set, go_poll;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            // With init disabled, start in WAIT and let first_q force an immediate poll.
            state_q <= INIT_EN ? S_INIT : S_WAIT;
            first_q <= !INIT_EN;
            step_q  <= '0;
            issue_q <= 1'b0;
            call_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            poll_q  <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            sh02_q  <= '0;
            sh03_q  <= '0;
            smin_q  <= '0;
            shour_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            vl_q    <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            step_q  <= step_d;
            issue_q <= issue_d;
            call_q  <= call_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            poll_q  <= poll_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            sh02_q  <= sh02_d;
            sh03_q  <= sh03_d;
            smin_q  <= smin_d;
            shour_q <= shour_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            vl_q    <= vl_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        step_d  = step_q;
        issue_d = issue_q;
        call_d  = call_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        poll_d  = poll_q;
        pend_d  = pend_q;
        err_d   = err_q;
        sh02_d  = sh02_q;
        sh03_d  = sh03_q;
        smin_d  = smin_q;
        shour_d = shour_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        vl_d    = vl_q;
        valid_d = 1'b0;
        ack_d   = 1'b0;
        go_set  = 1'b0;
        go_poll = 1'b0;

        if (iSetReq && (state_q != S_WAIT)) pend_d = 1'b1;

        case (state_q)
            S_WAIT: begin
                poll_d = poll_q + PC_W'(1);
                if (pend_q || iSetReq) go_set = 1'b1;
                else if (first_q || (poll_q == POLL_LAST)) go_poll = 1'b1;
            end
            S_PUBLISH: begin
                if (pend_q || iSetReq) go_set = 1'b1;
                else state_d = S_WAIT;
            end
            default: begin
                // Address/data were loaded on the previous edge, so this gap cycle
                // only raises the call; it is then held until iDone.
                if (!issue_q) begin
                    issue_d = 1'b1;
                    tmo_d   = '0;
                    call_d  = (state_q == S_POLL) ? CALL_RD : CALL_WR;
                end else begin
                    if (tmo_q == TO_LAST) err_d = 1'b1;
                    else tmo_d = tmo_q + TO_W'(1);
                    if (iDone) begin
                        issue_d = 1'b0;
                        call_d  = 2'b00;
                        step_d  = step_q + 2'd1;
                        case (state_q)
                            S_INIT: begin
                                if (step_q == 2'd0) begin
                                    addr_d  = 8'h01;
                                    wdata_d = 8'h00;
                                end else begin
                                    go_poll = 1'b1;
                                end
                            end
                            S_POLL: begin
                                case (step_q)
                                    2'd0: begin
                                        sh02_d = iRdData;
                                        addr_d = 8'h03;
                                    end
                                    2'd1: begin
                                        sh03_d = iRdData & 8'h7F;
                                        addr_d = 8'h04;
                                    end
                                    default: begin
                                        sec_d   = {1'b0, sh02_q[6:0]};
                                        min_d   = sh03_q;
                                        hour_d  = iRdData & 8'h3F;
                                        vl_d    = sh02_q[7];
                                        valid_d = 1'b1;
                                        state_d = S_PUBLISH;
                                    end
                                endcase
                            end
                            S_SET: begin
                                case (step_q)
                                    2'd0: begin
                                        addr_d  = 8'h03;
                                        wdata_d = smin_q;
                                    end
                                    2'd1: begin
                                        addr_d  = 8'h04;
                                        wdata_d = shour_q;
                                    end
                                    default: begin
                                        ack_d   = 1'b1;
                                        pend_d  = 1'b0;
                                        go_poll = 1'b1;
                                    end
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // Set values are sampled here, at group entry; seconds bit7=0 clears VL.
        if (go_set) begin
            state_d = S_SET;
            step_d  = '0;
            issue_d = 1'b0;
            poll_d  = '0;
            addr_d  = 8'h02;
            wdata_d = iSetSec & 8'h7F;
            smin_d  = iSetMin & 8'h7F;
            shour_d = iSetHour & 8'h3F;
        end
        if (go_poll) begin
            state_d = S_POLL;
            step_d  = '0;
            issue_d = 1'b0;
            poll_d  = '0;
            first_d = 1'b0;
            addr_d  = 8'h02;
        end
    end

    assign oCall   = call_q;
    assign oAddr   = addr_q;
    assign oWrData = wdata_q;
    assign oSetAck = ack_q;
    assign oSec    = sec_q;
    assign oMin    = min_q;
    assign oHour   = hour_q;
    assign oVL     = vl_q;
    assign oValid  = valid_q;
    assign oBusy   = (state_q != S_WAIT);
    assign oErr    = err_q;

endmodule
